// File: rtl/modulo_output_if.sv
// modulo_output_if - signal bundle between the processor OUT port and the
// board output stage.
//   escrita       : OUT strobe level, slow processor-clock domain
//   dado          : two's-complement value to display
//   continuar     : debounced continue button level (1 = pressed)
//   ocupado       : conversion in progress
//   aguardando    : value shown, waiting for continue (selects pause mode 2)
//   valor_exibido : last captured dado
//   hex0..hex4    : active-low decimal digits {g,f,e,d,c,b,a}, hex0 = units
//   hex5          : active-low sign display
// master = processor/board side, slave = the output stage itself.
`timescale 1ns/1ps
interface modulo_output_if;
  logic        escrita;
  logic [15:0] dado;
  logic        continuar;
  logic        ocupado;
  logic        aguardando;
  logic [15:0] valor_exibido;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;
  logic [6:0]  hex4;
  logic [6:0]  hex5;

  modport master (
    output escrita, dado, continuar,
    input  ocupado, aguardando, valor_exibido,
    input  hex0, hex1, hex2, hex3, hex4, hex5
  );

  modport slave (
    input  escrita, dado, continuar,
    output ocupado, aguardando, valor_exibido,
    output hex0, hex1, hex2, hex3, hex4, hex5
  );
endinterface

// File: rtl/modulo_output.sv
// modulo_output - output side of the board I/O.
// Captures the value written by an OUT instruction, converts its magnitude
// to decimal with a sequential double-dabble (16 shifts), shows it on six
// active-low 7-segment displays and, when PAUSA_EM_OUT = 1, holds
// aguardando until the continue button is pressed and released.
// Ports:
//   clock   : 50 MHz system clock
//   reset_n : asynchronous active-low reset
//   bus     : modulo_output_if.slave (strobe, data, continue, status, displays)
`timescale 1ns/1ps
module modulo_output #(
  parameter bit PAUSA_EM_OUT = 1'b1
) (
  input  logic            clock,
  input  logic            reset_n,
  modulo_output_if.slave  bus
);

  typedef enum logic [1:0] {OCIOSO, CONVERTE, EXIBE, LIBERA} estado_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MENOS = 7'h3F;

  estado_t     estado;
  logic        escrita_d;
  logic        sinal;
  logic [15:0] mag;
  logic [19:0] bcd;
  logic [3:0]  cnt;
  logic        ocupado_q;
  logic        aguardando_q;
  logic [15:0] valor_q;
  logic [6:0]  hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q;

  logic        nova_escrita;
  logic [15:0] mag_in;
  logic [19:0] bcd_adj;
  logic [19:0] bcd_next;
  logic [15:0] mag_next;
  logic [6:0]  disp0, disp1, disp2, disp3, disp4;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // escrita_d resets to 1 so a strobe already high at reset release
  // does not look like a rising edge.
  assign nova_escrita = bus.escrita & ~escrita_d;

  // 16-bit unsigned magnitude; 16'h8000 negates to itself, read as 32768.
  assign mag_in = bus.dado[15] ? (~bus.dado + 16'd1) : bus.dado;

  // One double-dabble step: correct nibbles >= 5, then shift {bcd, mag}.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 5; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                   : bcd[4*i +: 4];
    end
  end

  assign {bcd_next, mag_next} = {bcd_adj, mag} << 1;

  // Leading-zero suppression: a digit is blank while it and every higher
  // digit are zero; the units digit is always shown.
  always_comb begin
    logic b4, b3, b2, b1;
    b4 = (bcd_next[19:16] == 4'd0);
    b3 = b4 && (bcd_next[15:12] == 4'd0);
    b2 = b3 && (bcd_next[11:8] == 4'd0);
    b1 = b2 && (bcd_next[7:4] == 4'd0);
    disp4 = b4 ? SEG_BLANK : seg7(bcd_next[19:16]);
    disp3 = b3 ? SEG_BLANK : seg7(bcd_next[15:12]);
    disp2 = b2 ? SEG_BLANK : seg7(bcd_next[11:8]);
    disp1 = b1 ? SEG_BLANK : seg7(bcd_next[7:4]);
    disp0 = seg7(bcd_next[3:0]);
  end

  // Main FSM with registered status and display outputs. Write edges
  // outside OCIOSO are dropped while escrita_d keeps tracking, so a
  // strobe that stays high never produces a second capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado       <= OCIOSO;
      escrita_d    <= 1'b1;
      sinal        <= 1'b0;
      mag          <= '0;
      bcd          <= '0;
      cnt          <= '0;
      ocupado_q    <= 1'b0;
      aguardando_q <= 1'b0;
      valor_q      <= '0;
      hex0_q       <= SEG_BLANK;
      hex1_q       <= SEG_BLANK;
      hex2_q       <= SEG_BLANK;
      hex3_q       <= SEG_BLANK;
      hex4_q       <= SEG_BLANK;
      hex5_q       <= SEG_BLANK;
    end else begin
      escrita_d <= bus.escrita;
      case (estado)
        OCIOSO: begin
          if (nova_escrita) begin
            valor_q   <= bus.dado;
            sinal     <= bus.dado[15];
            mag       <= mag_in;
            bcd       <= '0;
            cnt       <= '0;
            ocupado_q <= 1'b1;
            estado    <= CONVERTE;
          end
        end
        CONVERTE: begin
          bcd <= bcd_next;
          mag <= mag_next;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            hex0_q    <= disp0;
            hex1_q    <= disp1;
            hex2_q    <= disp2;
            hex3_q    <= disp3;
            hex4_q    <= disp4;
            hex5_q    <= sinal ? SEG_MENOS : SEG_BLANK;
            ocupado_q <= 1'b0;
            if (PAUSA_EM_OUT) begin
              aguardando_q <= 1'b1;
              estado       <= EXIBE;
            end else begin
              estado <= OCIOSO;
            end
          end
        end
        EXIBE: begin
          if (bus.continuar) begin
            aguardando_q <= 1'b0;
            estado       <= LIBERA;
          end
        end
        LIBERA: begin
          // Wait for the button to be released so one press frees one OUT.
          if (!bus.continuar) begin
            estado <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign bus.ocupado       = ocupado_q;
  assign bus.aguardando    = aguardando_q;
  assign bus.valor_exibido = valor_q;
  assign bus.hex0          = hex0_q;
  assign bus.hex1          = hex1_q;
  assign bus.hex2          = hex2_q;
  assign bus.hex3          = hex3_q;
  assign bus.hex4          = hex4_q;
  assign bus.hex5          = hex5_q;

endmodule

// File: doc/modulo_output.md
# modulo_output

Output side of the processor's board I/O, the counterpart to the switch/button input stage. It captures the value the processor emits on an OUT instruction and converts it from signed binary to decimal with a sequential double-dabble. It shows the result on six active-low 7-segment displays. It then raises a wait flag that the clock-generation logic uses to select pause mode 2, and holds it until the debounced continue button releases it.

## Interface
Parameters:
- PAUSA_EM_OUT, 1, 1 = hold `aguardando` after each OUT until continue; 0 = display only, no wait.

Ports:
- clock  in  1  50 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- escrita  in  1  OUT strobe from the processor, a level in the slow processor-clock domain. Its rising edge starts a capture.
- dado  in  16  two's-complement value to display.
- continuar  in  1  debounced continue button level (1 = pressed).
- ocupado  out  1  conversion in progress.
- aguardando  out  1  value shown, waiting for continue. Drives pause = 2.
- valor_exibido  out  16  last captured `dado`.
- hex0..hex4  out  7 each  decimal digits, hex0 = units. Active-low, bit order {g,f,e,d,c,b,a}.
- hex5  out  7  sign display.

## Operation
- Edge detect: `escrita_d` is registered every cycle. A new write is `escrita & ~escrita_d`. `escrita_d` resets to 1, so a level already high when reset releases is not treated as a write.
- FSM states:
  - OCIOSO
    - On a new write: latch `dado` into `valor_exibido`.
    - Latch sign = dado[15] and magnitude = |dado|. Magnitude is 16-bit unsigned, so 16'h8000 gives 32768.
    - Clear the 20-bit BCD register and the shift counter, then go to CONVERTE.
  - CONVERTE
    - Each cycle: add 3 to every BCD nibble ≥ 5, then shift {bcd, mag} left by 1.
    - After the 16th shift, load the display registers from the BCD result.
    - Then go to EXIBE if PAUSA_EM_OUT = 1, else OCIOSO.
  - EXIBE: `aguardando` = 1. When continuar = 1, go to LIBERA.
  - LIBERA: when continuar = 0, go to OCIOSO. This keeps one press from releasing two OUTs.
- Write edges in CONVERTE, EXIBE and LIBERA are dropped. `escrita_d` keeps tracking throughout.
- Display encoding (active-low):
  - Digits 0–9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex, 7-bit).
  - Blank = 7F.
- Leading-zero suppression: hex4..hex1 are blank while they and every higher digit are 0. hex0 always shows a digit.
- hex5 = 3F (minus sign, segment g lit) when the value is negative, else 7F.
- `ocupado` = 1 exactly while in CONVERTE.

## Timing
- Reset values:
  - State OCIOSO.
  - hex0..hex5 = 7F.
  - valor_exibido = 0; ocupado = 0; aguardando = 0; escrita_d = 1.
- Reset mid-operation: immediate return to the reset values. Any conversion in progress is discarded.
- Capture and conversion:
  - Let t0 be the posedge at which a new write is sampled in OCIOSO. `dado` is captured at t0.
  - Shifts happen on t0+1 … t0+16. Displays and `aguardando` update at t0+16, a latency of 16 cycles.
  - `ocupado` is high after t0 and low after t0+16.
  - `dado` must be stable at t0 only.
- Release handshake:
  - `aguardando` falls on the posedge after `continuar` is first sampled high.
  - A new write is accepted no earlier than one cycle after `continuar` is sampled low.
- PAUSA_EM_OUT = 0: OCIOSO is re-entered at t0+16, so the next write edge can be accepted from t0+17.
- A write edge coinciding with the return to OCIOSO is not captured, because the edge must be sampled while already in OCIOSO.

## Test plan
- Reset, then release with escrita = 0 -> all hex = 7F, ocupado = 0, aguardando = 0, valor_exibido = 0.
- dado = 1234, escrita rises -> ocupado high for 16 cycles; hex3..0 = 79, 24, 30, 19; hex4 = 7F, hex5 = 7F; aguardando = 1; valor_exibido = 16'h04D2.
- dado = 16'h8000 -> hex4..0 = 30, 24, 78, 02, 00 (32768); hex5 = 3F.
- dado = 0 -> hex0 = 40, hex1..hex5 = 7F.
- Continue handshake and ignored edges:
  - In EXIBE, hold continuar = 1 and toggle escrita -> aguardando falls one cycle later; no new capture.
  - Drop continuar, then raise escrita -> new conversion runs.
- Reset and held strobe:
  - escrita held high for 100 cycles -> exactly one conversion.
  - Assert reset_n = 0 at t0+8 with escrita still high, then release -> displays stay 7F, state stays OCIOSO, no conversion.
